// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_sequencer
//  Description : Raster timing generator and frame-synchronous pattern
//                sequencer for the HDMI test image generator. Produces the
//                scan position, data enable, sync strobes and the pattern
//                control set (sel, step_count, frame_count, time_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
   parameter int H_ACTIVE     = 1920,
   parameter int H_TOTAL      = 2200,
   parameter int H_SYNC_START = 2008,
   parameter int H_SYNC_LEN   = 44,
   parameter int V_ACTIVE     = 1080,
   parameter int V_TOTAL      = 1125,
   parameter int V_SYNC_START = 1084,
   parameter int V_SYNC_LEN   = 5,
   parameter int NUM_PATTERNS = 5,
   parameter int DWELL_FRAMES = 60,
   parameter int TICK_DIV     = 148500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        auto_mode,
   input  logic [3:0]  manual_sel,
   input  logic        next_req,
   output logic [11:0] h_active_value,
   output logic [11:0] v_active_value,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  sel,
   output logic [11:0] step_count,
   output logic [23:0] time_count,
   output logic [7:0]  frame_count,
   output logic        frame_start
);

   localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0]         c_st_idle    = 2'd0;
   localparam logic [1:0]         c_st_run     = 2'd1;
   localparam logic [1:0]         c_st_drain   = 2'd2;
   localparam logic [11:0]        c_h_last     = 12'(H_TOTAL - 1);
   localparam logic [11:0]        c_v_last     = 12'(V_TOTAL - 1);
   localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DWELL_FRAMES - 1);
   localparam logic [TICK_W-1:0]  c_tick_last  = TICK_W'(TICK_DIV - 1);
   localparam logic [3:0]         c_sel_last   = 4'(NUM_PATTERNS - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nx;
   logic [11:0]        w_h_nx;
   logic [11:0]        w_v_nx;
   logic               w_boundary;
   logic               w_scan_nx;
   logic               w_de_nx;
   logic               w_hsync_nx;
   logic               w_vsync_nx;
   logic               w_fs_nx;
   logic               w_advance;
   logic [3:0]         w_sel_nx;
   logic [11:0]        w_step_nx;
   logic [7:0]         w_frame_nx;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] w_dwell_nx;
   logic               r_pending;
   logic               w_pending_nx;
   logic [TICK_W-1:0]  r_tick;

   // State register together with the scan counters it owns
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= c_st_idle;
         h_active_value <= '0;
         v_active_value <= '0;
      end else begin
         r_state        <= w_state_nx;
         h_active_value <= w_h_nx;
         v_active_value <= w_v_nx;
      end
   end

   // Next-state and next-position logic; a frame ends on the last pixel of the last line
   always_comb begin
      w_state_nx = r_state;
      w_h_nx     = h_active_value;
      w_v_nx     = v_active_value;
      w_boundary = 1'b0;
      case (r_state)
         c_st_idle: begin
            w_h_nx = '0;
            w_v_nx = '0;
            if (enable) begin
               w_state_nx = c_st_run;
            end
         end
         c_st_run, c_st_drain: begin
            w_boundary = (h_active_value == c_h_last) && (v_active_value == c_v_last);
            if (h_active_value == c_h_last) begin
               w_h_nx = '0;
               w_v_nx = (v_active_value == c_v_last) ? 12'd0 : v_active_value + 12'd1;
            end else begin
               w_h_nx = h_active_value + 12'd1;
            end
            // Disabled at the frame end (from RUN or DRAIN) stops cleanly; otherwise
            // enable alone chooses between scanning on and draining the frame out.
            if (w_boundary && !enable) begin
               w_state_nx = c_st_idle;
            end else if (enable) begin
               w_state_nx = c_st_run;
            end else begin
               w_state_nx = c_st_drain;
            end
         end
         default: begin
            w_state_nx = c_st_idle;
            w_h_nx     = '0;
            w_v_nx     = '0;
         end
      endcase
   end

   // Output decode from the next position, plus frame-boundary pattern update
   always_comb begin
      w_scan_nx    = (w_state_nx != c_st_idle);
      w_de_nx      = w_scan_nx && (int'(w_h_nx) < H_ACTIVE) && (int'(w_v_nx) < V_ACTIVE);
      w_hsync_nx   = w_scan_nx && (int'(w_h_nx) >= H_SYNC_START)
                     && (int'(w_h_nx) < H_SYNC_START + H_SYNC_LEN);
      w_vsync_nx   = w_scan_nx && (int'(w_v_nx) >= V_SYNC_START)
                     && (int'(w_v_nx) < V_SYNC_START + V_SYNC_LEN);
      w_fs_nx      = w_scan_nx && (w_h_nx == 12'd0) && (w_v_nx == 12'd0);
      w_advance    = 1'b0;
      w_sel_nx     = sel;
      w_step_nx    = step_count;
      w_frame_nx   = frame_count;
      w_dwell_nx   = r_dwell;
      w_pending_nx = r_pending;
      if (w_boundary) begin
         w_frame_nx = frame_count + 8'd1;
         if (auto_mode) begin
            // A request arriving on the boundary cycle itself is honoured now
            w_advance = (r_dwell == c_dwell_last) || r_pending || next_req;
            if (w_advance) begin
               w_sel_nx     = (sel >= c_sel_last) ? 4'd0 : sel + 4'd1;
               w_dwell_nx   = '0;
               w_pending_nx = 1'b0;
            end else begin
               w_dwell_nx = r_dwell + 1'b1;
            end
         end else begin
            w_sel_nx     = manual_sel;
            w_dwell_nx   = '0;
            w_pending_nx = 1'b0;
         end
         w_step_nx = (w_sel_nx == sel) ? step_count + 12'd1 : 12'd0;
      end else if (auto_mode && next_req) begin
         w_pending_nx = 1'b1;
      end
   end

   // Registered outputs and pattern-control state
   always_ff @(posedge clk) begin
      if (rst) begin
         de          <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         frame_start <= 1'b0;
         sel         <= '0;
         step_count  <= '0;
         frame_count <= '0;
         r_dwell     <= '0;
         r_pending   <= 1'b0;
      end else begin
         de          <= w_de_nx;
         hsync       <= w_hsync_nx;
         vsync       <= w_vsync_nx;
         frame_start <= w_fs_nx;
         sel         <= w_sel_nx;
         step_count  <= w_step_nx;
         frame_count <= w_frame_nx;
         r_dwell     <= w_dwell_nx;
         r_pending   <= w_pending_nx;
      end
   end

   // Free-running time base, independent of the raster state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick     <= '0;
         time_count <= '0;
      end else if (r_tick == c_tick_last) begin
         r_tick     <= '0;
         time_count <= time_count + 24'd1;
      end else begin
         r_tick <= r_tick + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_sequencer
//  Description : Self-checking bench for pattern_sequencer with small raster
//                parameters, a frame-level reference model, a vector table
//                and directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pattern_sequencer;

   localparam int HA = 8,  HT = 12, HSS = 9, HSL = 2;
   localparam int VA = 4,  VT = 6,  VSS = 4, VSL = 1;
   localparam int NP = 5,  DW = 3,  TD = 4;

   logic        clk = 1'b0;
   logic        rst, enable, auto_mode, next_req;
   logic [3:0]  manual_sel;
   logic [11:0] h_active_value, v_active_value, step_count;
   logic        de, hsync, vsync, frame_start;
   logic [3:0]  sel;
   logic [23:0] time_count;
   logic [7:0]  frame_count;

   always #5 clk = ~clk;

   pattern_sequencer #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
      .NUM_PATTERNS(NP), .DWELL_FRAMES(DW), .TICK_DIV(TD)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .auto_mode(auto_mode),
      .manual_sel(manual_sel), .next_req(next_req),
      .h_active_value(h_active_value), .v_active_value(v_active_value),
      .de(de), .hsync(hsync), .vsync(vsync), .sel(sel),
      .step_count(step_count), .time_count(time_count),
      .frame_count(frame_count), .frame_start(frame_start)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: scan position, frame-level pattern state, clocks since reset
   bit m_active;
   int m_h, m_v, m_sel, m_step, m_frame, m_dwell, m_clk;
   bit m_pend;
   bit m_time_chk = 1'b1;

   typedef struct {
      int c; int h; int v; bit de; bit hs; bit vs; bit fs; int sel; int step; int fr;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_step();
      int new_sel;
      if (rst) begin
         m_active = 0; m_h = 0; m_v = 0; m_sel = 0; m_step = 0;
         m_frame = 0; m_dwell = 0; m_pend = 0; m_clk = 0;
      end else begin
         m_clk++;
         if (!m_active) begin
            if (enable) m_active = 1;
            if (auto_mode && next_req) m_pend = 1;
         end else if (m_h == HT - 1 && m_v == VT - 1) begin
            m_frame = (m_frame + 1) % 256;
            if (auto_mode) begin
               if (m_dwell == DW - 1 || m_pend || next_req) begin
                  new_sel = (m_sel + 1 >= NP) ? 0 : m_sel + 1;
                  m_dwell = 0; m_pend = 0;
               end else begin
                  new_sel = m_sel; m_dwell++;
               end
            end else begin
               new_sel = manual_sel; m_dwell = 0; m_pend = 0;
            end
            m_step = (new_sel == m_sel) ? (m_step + 1) % 4096 : 0;
            m_sel  = new_sel;
            m_h = 0; m_v = 0;
            if (!enable) m_active = 0;
         end else begin
            m_h++;
            if (m_h == HT) begin m_h = 0; m_v++; end
            if (auto_mode && next_req) m_pend = 1;
         end
      end
   endtask

   task automatic check_model();
      chk("h", h_active_value, m_h);
      chk("v", v_active_value, m_v);
      chk("de", de, m_active && m_h < HA && m_v < VA);
      chk("hsync", hsync, m_active && m_h >= HSS && m_h < HSS + HSL);
      chk("vsync", vsync, m_active && m_v >= VSS && m_v < VSS + VSL);
      chk("frame_start", frame_start, m_active && m_h == 0 && m_v == 0);
      chk("sel", sel, m_sel);
      chk("step_count", step_count, m_step);
      chk("frame_count", frame_count, m_frame);
      if (m_time_chk) chk("time_count", time_count, (m_clk / TD) % (1 << 24));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) begin tick(); cyc++; end
   endtask

   task automatic do_reset();
      rst = 1; enable = 0; next_req = 0; auto_mode = 1; manual_sel = 0;
      tick(); tick();
      rst = 0; cyc = 0; m_time_chk = 1;
   endtask

   initial begin
      int de_cnt, hs_cnt, vs_cnt, fs_cnt;
      rst = 1; enable = 0; auto_mode = 1; manual_sel = 0; next_req = 0;

      // c: cycles after enable; expected h, v, de, hsync, vsync, frame_start, sel, step, frame
      vecs.push_back('{1,    0,  0, 1, 0, 0, 1, 0, 0, 0});
      vecs.push_back('{10,   9,  0, 0, 1, 0, 0, 0, 0, 0});
      vecs.push_back('{12,   11, 0, 0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{13,   0,  1, 1, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{57,   8,  4, 0, 0, 1, 0, 0, 0, 0});
      vecs.push_back('{73,   0,  0, 1, 0, 0, 1, 0, 1, 1});
      vecs.push_back('{217,  0,  0, 1, 0, 0, 1, 1, 0, 3});
      vecs.push_back('{1009, 0,  0, 1, 0, 0, 1, 4, 2, 14});
      vecs.push_back('{1081, 0,  0, 1, 0, 0, 1, 0, 0, 15});

      // Reset state
      do_reset();
      chk("rst_h", h_active_value, 0);   chk("rst_v", v_active_value, 0);
      chk("rst_de", de, 0);              chk("rst_sync", {hsync, vsync}, 0);
      chk("rst_fs", frame_start, 0);     chk("rst_sel", sel, 0);
      chk("rst_step", step_count, 0);    chk("rst_time", time_count, 0);
      chk("rst_frame", frame_count, 0);

      // Raster timing and auto cycling from the vector table
      enable = 1;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
      foreach (vecs[i]) begin
         while (cyc < vecs[i].c) begin
            tick(); cyc++;
            if (cyc <= 72) begin de_cnt += de; hs_cnt += hsync; vs_cnt += vsync; end
            fs_cnt += frame_start;
         end
         chk("vec_h", h_active_value, vecs[i].h);
         chk("vec_v", v_active_value, vecs[i].v);
         chk("vec_de", de, vecs[i].de);
         chk("vec_hsync", hsync, vecs[i].hs);
         chk("vec_vsync", vsync, vecs[i].vs);
         chk("vec_fs", frame_start, vecs[i].fs);
         chk("vec_sel", sel, vecs[i].sel);
         chk("vec_step", step_count, vecs[i].step);
         chk("vec_frame", frame_count, vecs[i].fr);
      end
      chk("de_per_frame", de_cnt, 32);
      chk("hsync_per_frame", hs_cnt, 12);
      chk("vsync_per_frame", vs_cnt, 12);
      chk("frame_starts", fs_cnt, 16);

      // next_req in frame 1, then again in the frame where dwell expires
      do_reset(); enable = 1;
      run_to(100); next_req = 1; tick(); cyc++; next_req = 0;
      run_to(145); chk("req_f2_sel", sel, 1); chk("req_f2_step", step_count, 0);
      run_to(289); chk("req_f4_sel", sel, 1); chk("req_f4_step", step_count, 2);
      run_to(361); chk("req_f5_sel", sel, 2);
      run_to(520); next_req = 1; tick(); cyc++; next_req = 0;
      run_to(577); chk("req_f8_sel", sel, 3);
      run_to(721); chk("req_f10_sel", sel, 3); chk("req_f10_step", step_count, 2);
      run_to(793); chk("req_f11_sel", sel, 4);

      // Manual select applied mid-frame takes effect at the boundary
      do_reset(); enable = 1;
      run_to(40); auto_mode = 0; manual_sel = 4'hA;
      run_to(72);  chk("man_old_sel", sel, 0);
      run_to(73);  chk("man_sel", sel, 10); chk("man_step0", step_count, 0);
      run_to(145); chk("man_sel2", sel, 10); chk("man_step1", step_count, 1);

      // Enable dropped mid-frame: frame completes, then idle
      do_reset(); enable = 1;
      run_to(16); chk("drop_h", h_active_value, 3); chk("drop_v", v_active_value, 1);
      enable = 0;
      run_to(72); chk("drain_h", h_active_value, 11); chk("drain_v", v_active_value, 5);
      run_to(73); chk("idle_h", h_active_value, 0); chk("idle_de", de, 0);
      chk("idle_fs", frame_start, 0); chk("idle_frame", frame_count, 1);
      run_to(80); chk("idle_hold_h", h_active_value, 0);

      // Re-enable during drain keeps scanning
      do_reset(); enable = 1;
      run_to(16); enable = 0; run_to(21); enable = 1;
      run_to(73); chk("reen_fs", frame_start, 1); chk("reen_frame", frame_count, 1);
      run_to(74); chk("reen_h", h_active_value, 1);

      // Time base: counts in idle and run; wrap from forced all-ones
      do_reset(); enable = 0;
      run_to(4);   chk("time_4", time_count, 1);
      run_to(50);  enable = 1;
      run_to(100); chk("time_100", time_count, 25);
      while (m_clk % TD != TD - 1) begin tick(); cyc++; end
      m_time_chk = 0;
      force dut.time_count = 24'hFFFFFF;
      #1;
      release dut.time_count;
      tick(); cyc++;
      chk("time_wrap", time_count, 0);
      tick(); cyc++;

      // Reset mid-frame
      rst = 1; tick(); rst = 0; m_time_chk = 1;
      chk("mid_rst_h", h_active_value, 0); chk("mid_rst_v", v_active_value, 0);
      chk("mid_rst_fs", frame_start, 0);   chk("mid_rst_time", time_count, 0);
      chk("mid_rst_frame", frame_count, 0);

      // Randomized stimulus against the reference model
      do_reset(); enable = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0)  enable = ~enable;
         if ($urandom_range(0, 299) == 0) auto_mode = ~auto_mode;
         manual_sel = 4'($urandom_range(0, 15));
         next_req   = ($urandom_range(0, 59) == 0);
         rst        = ($urandom_range(0, 1999) == 0);
         tick(); cyc++;
      end
      rst = 0; next_req = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Timing and pattern controller for the HDMI test image generator.
- Produces the raster scan position (h_active_value, v_active_value), data enable and sync strobes.
- Sequences the generator's control inputs: pattern select, step count, frame count and time count.
- All pattern-control changes occur only at frame boundaries, so each frame is rendered with one consistent control set.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_TOTAL, 2200, total clocks per line (H_TOTAL > H_ACTIVE, ≤ 4096)
H_SYNC_START, 2008, h_cnt at which hsync asserts
H_SYNC_LEN, 44, hsync width in clocks
V_ACTIVE, 1080, active lines per frame
V_TOTAL, 1125, total lines per frame (≤ 4096)
V_SYNC_START, 1084, v_cnt at which vsync asserts
V_SYNC_LEN, 5, vsync width in lines
NUM_PATTERNS, 5, auto mode cycles sel through 0..NUM_PATTERNS-1
DWELL_FRAMES, 60, frames per pattern in auto mode (≥ 1)
TICK_DIV, 148500, clocks per time_count increment (≥ 1)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
enable  in  1  run raster when high
auto_mode  in  1  1 = auto pattern cycling, 0 = manual select
manual_sel  in  4  pattern used in manual mode
next_req  in  1  single-cycle pulse: advance pattern (auto mode)
h_active_value  out  12  horizontal counter h_cnt
v_active_value  out  12  vertical counter v_cnt
de  out  1  high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
hsync  out  1  high for h_cnt in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN)
vsync  out  1  high for v_cnt in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN)
sel  out  4  pattern select to generator
step_count  out  12  per-pattern animation step
time_count  out  24  free-running time base
frame_count  out  8  completed-frame counter
frame_start  out  1  one-cycle pulse when h_cnt = 0 and v_cnt = 0 in RUN

Behaviour:
- Reset (rst high at a clk edge): state IDLE. All outputs 0, including sel, step_count, time_count, frame_count. Dwell counter 0, pending-advance flag 0.
- All outputs are registered. de, hsync and vsync are decoded from the next-state counters, so they align with the h/v outputs in the same cycle.
- FSM states:
  - IDLE: counters held at 0; de, hsync, vsync, frame_start = 0. If enable = 1, go to RUN; the next cycle shows h = 0, v = 0 with frame_start = 1.
  - RUN: h_cnt increments each clock. At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At v_cnt = V_TOTAL-1, v_cnt wraps to 0. If enable = 0, go to DRAIN.
  - DRAIN: scanning continues unchanged. If enable returns to 1, go back to RUN with no gap. At the frame boundary, go to IDLE instead of wrapping.
- Frame boundary = the cycle with h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, in RUN or DRAIN. On that edge:
  - frame_count += 1, wrapping 255 → 0.
  - Pattern update (below); then step_count += 1 (wrapping 4095 → 0) if sel is unchanged, else step_count = 0.
  - The new values are visible together with h = v = 0.
- Auto mode pattern update:
  - Dwell counter increments each boundary.
  - When dwell = DWELL_FRAMES-1, or the pending flag is set: sel advances (NUM_PATTERNS-1 → 0), dwell = 0, pending cleared.
  - Dwell expiry and pending in the same boundary produce one advance only.
- next_req: sets the pending flag on any cycle in auto mode; ignored in manual mode.
- Manual mode: sel = manual_sel at each boundary, any 4-bit value passed through unchanged. Dwell = 0, pending cleared.
- auto_mode / manual_sel changes take effect only at the next boundary. sel is never changed mid-frame or in IDLE.
- time_count: increments by 1 every TICK_DIV clocks, in every state, independent of enable. Wraps 2^24-1 → 0. Its prescaler is cleared by rst only.
- rst mid-frame: immediate return to reset values on that edge; no partial-frame updates.

Test Plan:
Small parameters for all scenarios: H_TOTAL = 12, H_ACTIVE = 8, H_SYNC_START = 9, H_SYNC_LEN = 2, V_TOTAL = 6, V_ACTIVE = 4, V_SYNC_START = 4, V_SYNC_LEN = 1, DWELL_FRAMES = 3, NUM_PATTERNS = 5, TICK_DIV = 4.
1. Reset release, enable = 1, auto_mode = 1:
   - frame_start at the first RUN cycle, then every 72 clocks.
   - de high for 32 clocks per frame.
   - hsync high at h = 9 and 10 only; vsync high for all of line 4.
2. Auto cycling:
   - sel sequence 0,0,0,1,1,1,2 … across frames; after sel = 4 it wraps to 0.
   - step_count = 0,1,2,0,1,2 …; frame_count increments every frame.
3. next_req pulsed in frame 1:
   - sel = 1 at the start of frame 2; dwell restarts, so sel = 2 at the start of frame 5.
   - next_req in the same frame the dwell expires → sel advances by exactly 1.
4. Manual mode, auto_mode = 0, manual_sel = 4'hA set mid-frame:
   - sel stays at its old value until the boundary, then reads 0xA.
   - step_count resets to 0, then increments every frame.
5. enable dropped at h = 3, v = 1:
   - Frame completes (frame_count += 1), then IDLE with h = v = de = 0.
   - Re-enable during DRAIN → continuous scanning, no IDLE.
6. time_count:
   - Reads 1 after 4 clocks and 25 after 100 clocks, including cycles spent in IDLE.
   - Preload 24'hFFFFFF via force → wraps to 0.
   - rst mid-frame → all outputs 0 on the next cycle.
